// File: rtl/serial_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Carry out of a full adder: majority of the three inputs.
    function automatic logic maj3(input logic x, input logic y, input logic c);
        return (x & y) | (x & c) | (y & c);
    endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// One full-adder slice with its carry flip-flop; sum bit is combinational.
// Latency: z is combinational, carry updates on the next falling edge of cp.
// Backpressure: none; load wins over the carry update.
module serial_fa_cell
    import serial_pkg::*;
(
    input  logic cp,
    input  logic rst_n,
    input  logic load,
    input  logic cin_init,
    input  logic a,
    input  logic b,
    output logic z,
    output logic carry
);

    assign z = a ^ b ^ carry;

    // Carry register: seeded on load (0 for add, 1 for the +1 of subtract),
    // otherwise follows the full-adder carry. Outside RUN it free-runs on the
    // drained (zero) operand bits, which is harmless because load reseeds it.
    always_ff @(negedge cp or negedge rst_n) begin
        if (!rst_n) begin
            carry <= 1'b0;
        end else if (load) begin
            carry <= cin_init;
        end else begin
            carry <= maj3(a, b, carry);
        end
    end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit add/subtract, LSB first, one bit per falling edge of cp.
// Latency: WIDTH cycles from the accepting edge to the done pulse.
// Backpressure: start is only honoured in IDLE or DONE; start during RUN is dropped.
module serial_addsub
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             cp,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             z,
    output logic             z_valid
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             running;
    logic             last_step;
    logic             fa_z;
    logic             carry;
    logic             carry_out;

    assign accept    = start && ((state == IDLE) || (state == DONE));
    assign running   = (state == RUN);
    assign last_step = running && (cnt == LAST);

    // Carry produced by the step in flight; on the MSB step this is the final carry.
    assign carry_out = maj3(a_sr[0], b_sr[0], carry);

    serial_fa_cell u_fa (
        .cp       (cp),
        .rst_n    (rst_n),
        .load     (accept),
        .cin_init (sub),
        .a        (a_sr[0]),
        .b        (b_sr[0]),
        .z        (fa_z),
        .carry    (carry)
    );

    assign busy    = running;
    assign done    = (state == DONE);
    assign z_valid = running;
    assign z       = running & fa_z;

    // State register.
    always_ff @(negedge cp or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; DONE with start held goes straight back to RUN.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand shifters, bit counter and result capture.
    // Subtract is a + ~b + 1: B is loaded inverted and the carry seeded with 1.
    // The carry register during the MSB step is the carry into the MSB, so the
    // signed overflow is that value XOR the final carry.
    always_ff @(negedge cp or negedge rst_n) begin
        if (!rst_n) begin
            a_sr <= '0;
            b_sr <= '0;
            cnt  <= '0;
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else if (accept) begin
            a_sr <= a;
            b_sr <= sub ? ~b : b;
            cnt  <= '0;
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else if (running) begin
            a_sr <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr <= {1'b0, b_sr[WIDTH-1:1]};
            sum  <= {fa_z, sum[WIDTH-1:1]};
            cnt  <= cnt + CW'(1);
            if (last_step) begin
                cout <= carry_out;
                ovf  <= carry ^ carry_out;
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub at WIDTH = 2, 8 and 32.
// Latency: n/a.
// Backpressure: n/a.
module tb_serial_addsub;

    logic        cp = 1'b0;
    logic        rst_n;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        sub_in;
    logic        st2, st8, st32;

    logic        busy2, done2, cout2, ovf2, z2, zv2;
    logic [1:0]  sum2;
    logic        busy8, done8, cout8, ovf8, z8, zv8;
    logic [7:0]  sum8;
    logic        busy32, done32, cout32, ovf32, z32, zv32;
    logic [31:0] sum32;

    int checks = 0;
    int errors = 0;
    int sel    = 8;

    logic        o_busy, o_done, o_cout, o_ovf, o_z, o_zv;
    logic [31:0] o_sum;

    always #5 cp = ~cp;

    serial_addsub #(.WIDTH(2)) u_w2 (
        .cp(cp), .rst_n(rst_n), .start(st2), .sub(sub_in),
        .a(a_in[1:0]), .b(b_in[1:0]),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2),
        .ovf(ovf2), .z(z2), .z_valid(zv2)
    );

    serial_addsub #(.WIDTH(8)) u_w8 (
        .cp(cp), .rst_n(rst_n), .start(st8), .sub(sub_in),
        .a(a_in[7:0]), .b(b_in[7:0]),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8),
        .ovf(ovf8), .z(z8), .z_valid(zv8)
    );

    serial_addsub #(.WIDTH(32)) u_w32 (
        .cp(cp), .rst_n(rst_n), .start(st32), .sub(sub_in),
        .a(a_in), .b(b_in),
        .busy(busy32), .done(done32), .sum(sum32), .cout(cout32),
        .ovf(ovf32), .z(z32), .z_valid(zv32)
    );

    // Route the instance under test to a common set of observation signals.
    always_comb begin
        o_busy = busy8; o_done = done8; o_sum = {24'd0, sum8};
        o_cout = cout8; o_ovf = ovf8; o_z = z8; o_zv = zv8;
        case (sel)
            2: begin
                o_busy = busy2; o_done = done2; o_sum = {30'd0, sum2};
                o_cout = cout2; o_ovf = ovf2; o_z = z2; o_zv = zv2;
            end
            32: begin
                o_busy = busy32; o_done = done32; o_sum = sum32;
                o_cout = cout32; o_ovf = ovf32; o_z = z32; o_zv = zv32;
            end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (w=%0d t=%0t)", tag, got, exp, sel, $time);
        end
    endtask

    task automatic set_start(input int w, input logic v);
        case (w)
            2:       st2  = v;
            32:      st32 = v;
            default: st8  = v;
        endcase
    endtask

    // Reference: plain integer arithmetic on the unsigned and signed readings.
    // Returns {ovf, cout, sum}.
    function automatic logic [33:0] ref_op(input int w, input logic [31:0] a,
                                           input logic [31:0] b, input logic s);
        longint m, ua, ub, sa, sb, half, res;
        logic [31:0] sm;
        logic co, ov;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua   = longint'(a) & m;
        ub   = longint'(b) & m;
        sa   = (ua >= half) ? ua - (m + 1) : ua;
        sb   = (ub >= half) ? ub - (m + 1) : ub;
        if (s) begin
            sm  = 32'((ua - ub) & m);
            co  = (ua >= ub);
            res = sa - sb;
        end else begin
            sm  = 32'((ua + ub) & m);
            co  = ((ua + ub) > m);
            res = sa + sb;
        end
        ov = (res >= half) || (res < -half);
        return {ov, co, sm};
    endfunction

    // One operation on instance w. poke >= 0 pulses start with different operands
    // in that RUN cycle (0-based), which must be ignored.
    task automatic do_op(input int w, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [31:0] e_sum, input logic e_co,
                         input logic e_ov, input int poke);
        logic [31:0] zacc;
        zacc = '0;
        @(posedge cp);
        sel = w; a_in = a; b_in = b; sub_in = s;
        set_start(w, 1'b1);
        for (int i = 0; i < w; i++) begin
            @(posedge cp);
            if (i == 0) begin
                set_start(w, 1'b0);
                chk("busy_run", 32'(o_busy), 32'd1);
            end
            zacc[i] = o_z;
            chk("z_valid_run", 32'(o_zv), 32'd1);
            chk("done_early", 32'(o_done), 32'd0);
            if (i == poke) begin
                a_in = ~a; b_in = a ^ 32'h5A5A_A5A5; sub_in = ~s;
                set_start(w, 1'b1);
            end else if (i == poke + 1) begin
                set_start(w, 1'b0);
            end
        end
        set_start(w, 1'b0);
        @(posedge cp);
        chk("done", 32'(o_done), 32'd1);
        chk("busy_done", 32'(o_busy), 32'd0);
        chk("z_valid_done", 32'(o_zv), 32'd0);
        chk("sum", o_sum, e_sum);
        chk("cout", 32'(o_cout), 32'(e_co));
        chk("ovf", 32'(o_ovf), 32'(e_ov));
        chk("z_stream", zacc, e_sum);
    endtask

    task automatic rand_op(input int w);
        logic [31:0] ra, rb;
        logic        rs;
        logic [33:0] r;
        ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
        r  = ref_op(w, ra, rb, rs);
        do_op(w, ra, rb, rs, r[31:0], r[32], r[33], -1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; a_in = '0; b_in = '0; sub_in = 1'b0;
        st2 = 1'b0; st8 = 1'b0; st32 = 1'b0;
        repeat (3) @(posedge cp);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_sum", o_sum, 32'd0);
        chk("rst_cout", 32'(o_cout), 32'd0);
        chk("rst_ovf", 32'(o_ovf), 32'd0);
        chk("rst_z", 32'(o_z), 32'd0);
        chk("rst_zv", 32'(o_zv), 32'd0);
        rst_n = 1'b1;

        // Directed vectors, WIDTH=8.
        do_op(8, 32'h3C, 32'h15, 1'b0, 32'h51, 1'b0, 1'b0, -1);
        do_op(8, 32'hFF, 32'h01, 1'b0, 32'h00, 1'b1, 1'b0, -1);
        do_op(8, 32'h7F, 32'h01, 1'b0, 32'h80, 1'b0, 1'b1, -1);
        do_op(8, 32'h10, 32'h20, 1'b1, 32'hF0, 1'b0, 1'b0, -1);
        do_op(8, 32'h80, 32'h01, 1'b1, 32'h7F, 1'b1, 1'b1, -1);

        // start pulsed in the 3rd RUN cycle must not disturb the operation.
        do_op(8, 32'h3C, 32'h15, 1'b0, 32'h51, 1'b0, 1'b0, 2);

        // start held high: back-to-back operations, done every WIDTH+1 cycles.
        @(posedge cp);
        sel = 8; a_in = 32'h3C; b_in = 32'h15; sub_in = 1'b0; st8 = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge cp);
            chk("b2b_done", 32'(o_done), ((k == 9) || (k == 18)) ? 32'd1 : 32'd0);
            if ((k == 9) || (k == 18)) chk("b2b_sum", o_sum, 32'h51);
            if (k == 18) st8 = 1'b0;
        end

        // Reset in the 4th RUN cycle aborts at once and suppresses done.
        @(posedge cp);
        sel = 8; a_in = 32'hA5; b_in = 32'h5B; sub_in = 1'b0; st8 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge cp);
            if (i == 0) st8 = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(o_busy), 32'd0);
        chk("abort_done", 32'(o_done), 32'd0);
        chk("abort_sum", o_sum, 32'd0);
        chk("abort_cout", 32'(o_cout), 32'd0);
        chk("abort_ovf", 32'(o_ovf), 32'd0);
        chk("abort_z", 32'(o_z), 32'd0);
        chk("abort_zv", 32'(o_zv), 32'd0);
        for (int k = 0; k < 10; k++) begin
            @(posedge cp);
            chk("abort_no_done", 32'(o_done), 32'd0);
        end
        rst_n = 1'b1;
        do_op(8, 32'hA5, 32'h5B, 1'b1, 32'h4A, 1'b1, 1'b1, -1);

        // Width extremes, directed then random.
        do_op(32, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1, 1'b0, -1);
        do_op(32, 32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, -1);
        do_op(2, 32'h1, 32'h1, 1'b0, 32'h2, 1'b0, 1'b1, -1);
        do_op(2, 32'h2, 32'h1, 1'b1, 32'h1, 1'b1, 1'b1, -1);
        for (int n = 0; n < 25; n++) rand_op(2);
        for (int n = 0; n < 25; n++) rand_op(8);
        for (int n = 0; n < 25; n++) rand_op(32);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
